smg_scan_decoder: RTL and testbench

- Receive-side monitor for the 2-digit multiplexed 7-segment scan bus that the display driver emits.
- Samples the select/segment lines each clock and decodes each digit pattern back to 0-9.
- Assembles ones+tens frames and publishes a debounced value 0..99 once it has seen STABLE_FRAMES identical consecutive frames.
- Used in board self-test and as a loopback checker beside the display path. It flags illegal segment patterns and scan stall.

---
 rtl/smg_pkg.sv | 31 +++
 rtl/smg_scan_decoder_if.sv | 8 +
 rtl/smg_seg_decode.sv | 28 ++
 rtl/smg_scan_decoder.sv | 128 ++++++++++++
 tb/tb_smg_scan_decoder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/smg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan bus.
// The display driver and the scan monitor both use this package.
package smg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [1:0] SEL_ONES = 2'b10;
    localparam logic [1:0] SEL_TENS = 2'b01;

    // Decimal point carries no digit information.
    localparam logic [7:0] DP_MASK = 8'h80;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_ONES = 1'b1
    } scan_state_t;

    function automatic logic [6:0] frame_value(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/smg_scan_decoder_if.sv
// Scan bus between the 7-segment display driver (master) and its monitors (slave).
interface smg_scan_decoder_if;
    logic [1:0] smg_sig;
    logic [7:0] smg_data;

    modport master (output smg_sig, output smg_data);
    modport slave  (input  smg_sig, input  smg_data);
endinterface

// File: rtl/smg_seg_decode.sv
// Combinational 7-segment pattern to decimal digit lookup; anything outside 0-9 is illegal.
module smg_seg_decode
    import smg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       illegal
);

    always_comb begin
        digit   = 4'd0;
        illegal = 1'b0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/smg_scan_decoder.sv
// Receive-side monitor for the 2-digit scan bus: decodes frames, debounces the value,
// flags illegal segment patterns and scan stall.
//   state  | meaning
//   S_SYNC | waiting for a ones digit to start a frame
//   S_ONES | ones digit held, waiting for the tens digit to complete the frame
module smg_scan_decoder
    import smg_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int TIMEOUT_CYC   = 16
) (
    input  logic                clk_1khz,
    input  logic                rst,
    smg_scan_decoder_if.slave   scan,
    output logic [6:0]          value,
    output logic                value_valid,
    output logic                update,
    output logic                seg_err,
    output logic                timeout
);

    localparam logic [3:0] STABLE_N  = 4'(STABLE_FRAMES);
    localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_CYC);

    scan_state_t state, state_n;
    logic [3:0]  ones, ones_n;
    logic [6:0]  cand, cand_n;
    logic [3:0]  stab_cnt, stab_n;
    logic [7:0]  stall_cnt, stall_n;
    logic [6:0]  value_n;
    logic        valid_n, update_n, seg_err_n, timeout_n;

    logic [6:0]  pattern;
    logic [3:0]  digit;
    logic        illegal;
    logic        sel_legal, sel_ones;
    logic [6:0]  frame;

    assign pattern   = 7'(scan.smg_data & ~DP_MASK);
    assign sel_ones  = (scan.smg_sig == SEL_ONES);
    assign sel_legal = sel_ones || (scan.smg_sig == SEL_TENS);
    assign frame     = frame_value(digit, ones);

    smg_seg_decode u_seg_decode (
        .pattern (pattern),
        .digit   (digit),
        .illegal (illegal)
    );

    always_ff @(posedge clk_1khz or negedge rst) begin
        if (!rst) begin
            state       <= S_SYNC;
            ones        <= 4'd0;
            cand        <= 7'd0;
            stab_cnt    <= 4'd0;
            stall_cnt   <= 8'd0;
            value       <= 7'd0;
            value_valid <= 1'b0;
            update      <= 1'b0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ones        <= ones_n;
            cand        <= cand_n;
            stab_cnt    <= stab_n;
            stall_cnt   <= stall_n;
            value       <= value_n;
            value_valid <= valid_n;
            update      <= update_n;
            seg_err     <= seg_err_n;
            timeout     <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ones_n    = ones;
        cand_n    = cand;
        stab_n    = stab_cnt;
        stall_n   = stall_cnt;
        value_n   = value;
        valid_n   = value_valid;
        timeout_n = timeout;
        update_n  = 1'b0;
        seg_err_n = 1'b0;

        if (sel_legal) begin
            stall_n   = 8'd0;
            timeout_n = 1'b0;
            if (illegal) begin
                // A legal select with garbage segments still proves the scan is alive.
                seg_err_n = 1'b1;
                state_n   = S_SYNC;
                stab_n    = 4'd0;
            end else if (sel_ones) begin
                ones_n  = digit;
                state_n = S_ONES;
            end else if (state == S_ONES) begin
                state_n = S_SYNC;
                if (frame == cand) begin
                    if (stab_cnt != STABLE_N)
                        stab_n = stab_cnt + 4'd1;
                end else begin
                    cand_n = frame;
                    stab_n = 4'd1;
                end
                if (stab_n == STABLE_N) begin
                    valid_n = 1'b1;
                    if ((value != cand_n) || !value_valid) begin
                        value_n  = cand_n;
                        update_n = 1'b1;
                    end
                end
            end
        end else begin
            if (stall_cnt != TIMEOUT_N)
                stall_n = stall_cnt + 8'd1;
            if (stall_n == TIMEOUT_N) begin
                timeout_n = 1'b1;
                valid_n   = 1'b0;
                state_n   = S_SYNC;
                stab_n    = 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_smg_scan_decoder.sv
// Self-checking bench for smg_scan_decoder: directed scan scenarios plus random traffic
// compared cycle by cycle against a frame-history reference model.
module tb_smg_scan_decoder;

    localparam int SF  = 4;
    localparam int TMO = 16;

    logic       clk;
    logic       rst;
    logic [6:0] value;
    logic       value_valid, update, seg_err, timeout;

    smg_scan_decoder_if bus ();

    smg_scan_decoder #(.STABLE_FRAMES(SF), .TIMEOUT_CYC(TMO)) dut (
        .clk_1khz    (clk),
        .rst         (rst),
        .scan        (bus),
        .value       (value),
        .value_valid (value_valid),
        .update      (update),
        .seg_err     (seg_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // Reference model: history of completed frames since the last disruption.
    int m_value, m_valid, m_timeout, m_update, m_seg_err;
    int have_ones, m_ones, idle;
    int frames[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int lookup(input int pat);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == pat) return i;
        return -1;
    endfunction

    function automatic bit locked();
        if (frames.size() < SF) return 1'b0;
        for (int i = frames.size() - SF; i < frames.size(); i++)
            if (frames[i] != frames[frames.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_value = 0; m_valid = 0; m_timeout = 0; m_update = 0; m_seg_err = 0;
        have_ones = 0; m_ones = 0; idle = 0;
        frames.delete();
    endtask

    task automatic model_step(input logic [1:0] sel, input logic [7:0] data);
        int d, f;
        m_update  = 0;
        m_seg_err = 0;
        if (sel == 2'b10 || sel == 2'b01) begin
            idle = 0;
            m_timeout = 0;
            d = lookup(int'(data & 8'h7F));
            if (d < 0) begin
                m_seg_err = 1;
                have_ones = 0;
                frames.delete();
            end else if (sel == 2'b10) begin
                m_ones = d;
                have_ones = 1;
            end else if (have_ones != 0) begin
                f = d * 10 + m_ones;
                have_ones = 0;
                frames.push_back(f);
                if (frames.size() > SF) void'(frames.pop_front());
                if (locked()) begin
                    if (m_value != f || m_valid == 0) begin
                        m_value  = f;
                        m_update = 1;
                    end
                    m_valid = 1;
                end
            end
        end else begin
            if (idle < TMO) idle++;
            if (idle == TMO) begin
                m_timeout = 1;
                m_valid   = 0;
                have_ones = 0;
                frames.delete();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".value"},   int'(value),       m_value);
        chk({tag, ".valid"},   int'(value_valid), m_valid);
        chk({tag, ".update"},  int'(update),      m_update);
        chk({tag, ".seg_err"}, int'(seg_err),     m_seg_err);
        chk({tag, ".timeout"}, int'(timeout),     m_timeout);
    endtask

    // Called at a negedge; drives one sample and checks outputs at the following negedge.
    task automatic cycle(input string tag, input logic [1:0] sel, input logic [7:0] data);
        bus.smg_sig  = sel;
        bus.smg_data = data;
        @(posedge clk);
        model_step(sel, data);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic send_frame(input string tag, input int tens, input int ones);
        logic [7:0] dp;
        dp = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'h00;
        cycle(tag, 2'b10, 8'(seg_tab[ones]) | dp);
        cycle(tag, 2'b01, 8'(seg_tab[tens]));
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 8'($urandom));
    endtask

    int upd_count;
    int pool[3];

    initial begin
        bus.smg_sig  = 2'b00;
        bus.smg_data = 8'h00;
        rst = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // 26 locks after four frames, one update only
        upd_count = 0;
        for (int i = 0; i < 8; i++) begin
            send_frame("lock26", 2, 6);
            upd_count += int'(update);
            if (i == 3) chk("lock26.update_at_4th", int'(update), 1);
        end
        chk("lock26.update_count", upd_count, 1);
        chk("lock26.value", int'(value), 26);

        // Illegal pattern while locked: seg_err, lock held
        cycle("segerr", 2'b10, 8'h01);
        chk("segerr.pulse", int'(seg_err), 1);
        chk("segerr.value_held", int'(value), 26);
        chk("segerr.valid_held", int'(value_valid), 1);
        cycle("segerr2", 2'b10, 8'h3F);
        chk("segerr.one_cycle", int'(seg_err), 0);

        // Change to 17 with a 19 glitch after the second frame
        send_frame("to17", 1, 7);
        send_frame("to17", 1, 7);
        send_frame("to17", 1, 9);
        for (int i = 0; i < 4; i++) begin
            send_frame("to17", 1, 7);
            chk("to17.update", int'(update), (i == 3) ? 1 : 0);
        end
        chk("to17.value", int'(value), 17);

        // Stall then resume at the same value
        idle_cycles("stall", TMO - 1);
        chk("stall.before", int'(timeout), 0);
        idle_cycles("stall", 1);
        chk("stall.timeout", int'(timeout), 1);
        chk("stall.valid", int'(value_valid), 0);
        chk("stall.value_kept", int'(value), 17);
        idle_cycles("stall", 5);
        cycle("resume", 2'b10, 8'(seg_tab[7]));
        chk("resume.timeout_clear", int'(timeout), 0);
        cycle("resume", 2'b01, 8'(seg_tab[1]));
        for (int i = 0; i < 3; i++) send_frame("resume", 1, 7);
        chk("resume.relock_update", int'(update), 1);

        // Leading tens digit is ignored
        cycle("lead_tens", 2'b01, 8'(seg_tab[4]));
        for (int i = 0; i < 4; i++) send_frame("lead42", 4, 2);
        chk("lead42.value", int'(value), 42);

        // Reset mid-frame
        cycle("midrst", 2'b10, 8'(seg_tab[3]));
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst.in_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) send_frame("post_rst05", 0, 5);
        chk("post_rst05.value", int'(value), 5);

        // Random traffic
        for (int i = 0; i < 3; i++) pool[i] = $urandom_range(0, 99);
        for (int it = 0; it < 400; it++) begin
            int r, v, p;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                idle_cycles("rnd.idle", $urandom_range(1, 20));
            end else if (r == 1) begin
                p = $urandom_range(0, 127);
                if (lookup(p) >= 0) p = 'h01;
                cycle("rnd.bad", ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01, 8'(p));
            end else if (r == 2) begin
                cycle("rnd.tens", 2'b01, 8'(seg_tab[$urandom_range(0, 9)]));
            end else if (r == 3) begin
                cycle("rnd.ones", 2'b10, 8'(seg_tab[$urandom_range(0, 9)]));
            end else begin
                v = pool[$urandom_range(0, 2)];
                if ($urandom_range(0, 3) != 0) v = pool[0];
                send_frame("rnd.frame", v / 10, v % 10);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
